// File: rtl/traffic_pkg.sv
// traffic_pkg: controller state encoding, lamp codes and the per-phase lamp decode.
package traffic_pkg;
   typedef enum logic [1:0] {GREEN, YELLOW, ALL_RED, EMERG_HOLD} state_t;
   localparam logic [2:0] LAMP_RED = 3'b100;
   localparam logic [2:0] LAMP_YEL = 3'b010;
   localparam logic [2:0] LAMP_GRN = 3'b001;
   function automatic logic [2:0] lamp_slice(input state_t s, input logic is_active);
      return (!is_active || s == ALL_RED) ? LAMP_RED : (s == YELLOW) ? LAMP_YEL : LAMP_GRN;
   endfunction
endpackage

// File: rtl/traffic_phase_select.sv
// traffic_phase_select: lowest-index emergency pick and round-robin demand search for the next green.
module traffic_phase_select #(
   parameter int NUM_PHASES = 4,
   localparam int PH_W = $clog2(NUM_PHASES)
) (
   input  logic [PH_W-1:0]       active_phase,
   input  logic [NUM_PHASES-1:0] demand,
   input  logic [NUM_PHASES-1:0] emergency,
   output logic                  emerg_any,
   output logic [PH_W-1:0]       emerg_idx,
   output logic [PH_W-1:0]       next_phase
);
   logic [PH_W-1:0] w_rr;
   always_comb begin
      emerg_idx = '0;
      for (int i = NUM_PHASES - 1; i >= 0; i--)
         if (emergency[i]) emerg_idx = PH_W'(i);
      w_rr = PH_W'((int'(active_phase) + 1) % NUM_PHASES);
      // scanning downward leaves the nearest requester after active_phase
      for (int k = NUM_PHASES - 1; k >= 1; k--)
         if (demand[(int'(active_phase) + k) % NUM_PHASES])
            w_rr = PH_W'((int'(active_phase) + k) % NUM_PHASES);
   end
   assign emerg_any  = |emergency;
   assign next_phase = emerg_any ? emerg_idx : w_rr;
endmodule

// File: rtl/traffic_phase_controller.sv
// traffic_phase_controller: N-phase signal controller with tick timebase, demand skipping and preemption.
// Define TRAFFIC_PED_WALK_EN to add ped_req/walk pedestrian service.
module traffic_phase_controller import traffic_pkg::*; #(
   parameter int NUM_PHASES = 4,
   parameter int TIMER_W = 8,
   localparam int PH_W = $clog2(NUM_PHASES)
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    tick,
   input  logic [TIMER_W-1:0]      green_time,
   input  logic [TIMER_W-1:0]      yellow_time,
   input  logic [TIMER_W-1:0]      allred_time,
   input  logic [NUM_PHASES-1:0]   demand,
   input  logic [NUM_PHASES-1:0]   emergency,
`ifdef TRAFFIC_PED_WALK_EN
   input  logic [NUM_PHASES-1:0]   ped_req,
   output logic [NUM_PHASES-1:0]   walk,
`endif
   output logic [3*NUM_PHASES-1:0] lights,
   output logic [PH_W-1:0]         active_phase,
   output logic                    emergency_active,
   output logic                    phase_start
);
   state_t r_state;
   logic [PH_W-1:0] r_phase;
   logic [TIMER_W-1:0] r_timer, r_dur;
   logic r_init, r_phase_start;
   logic w_emerg_any, w_exp, w_other;
   logic [PH_W-1:0] w_emerg_idx, w_next;
   logic [NUM_PHASES-1:0] w_dem;
   logic [TIMER_W-1:0] w_dur, w_tmr, w_gmin;

   function automatic logic [TIMER_W-1:0] min1(input logic [TIMER_W-1:0] v);
      return (v == '0) ? TIMER_W'(1) : v;
   endfunction

   traffic_phase_select #(.NUM_PHASES(NUM_PHASES)) u_sel (
      .active_phase(r_phase),
      .demand(w_dem),
      .emergency(emergency),
      .emerg_any(w_emerg_any),
      .emerg_idx(w_emerg_idx),
      .next_phase(w_next)
   );

   // the green duration cannot be a reset constant, so the first interval reads it live once
   assign w_gmin = min1(green_time);
   assign w_dur  = r_init ? w_gmin : r_dur;
   assign w_exp  = r_timer == w_dur;
   assign w_tmr  = (tick && !w_exp) ? r_timer + 1'b1 : r_timer;
   assign w_other = |(w_dem & ~(NUM_PHASES'(1) << r_phase));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= GREEN;
         r_phase       <= '0;
         r_timer       <= '0;
         r_dur         <= '0;
         r_init        <= 1'b1;
         r_phase_start <= 1'b0;
      end else begin
         r_init        <= 1'b0;
         r_phase_start <= 1'b0;
         r_timer       <= w_tmr;
         if (r_init) r_dur <= w_dur;
         case (r_state)
            GREEN:
               if (w_emerg_any && w_emerg_idx == r_phase) r_state <= EMERG_HOLD;
               else if (w_emerg_any || (w_exp && w_other)) begin
                  r_state <= YELLOW;
                  r_timer <= '0;
                  r_dur   <= min1(yellow_time);
               end
            YELLOW:
               if (w_exp) begin
                  r_state <= ALL_RED;
                  r_timer <= '0;
                  r_dur   <= min1(allred_time);
               end
            ALL_RED:
               if (w_exp) begin
                  r_state       <= GREEN;
                  r_phase       <= w_next;
                  r_timer       <= '0;
                  r_dur         <= w_gmin;
                  r_phase_start <= 1'b1;
               end
            EMERG_HOLD:
               if (!w_emerg_any) begin
                  r_state <= GREEN;
                  r_timer <= '0;
                  r_dur   <= w_gmin;
               end else if (w_emerg_idx != r_phase) begin
                  r_state <= YELLOW;
                  r_timer <= '0;
                  r_dur   <= min1(yellow_time);
               end
            default: r_state <= GREEN;
         endcase
      end
   end

   for (genvar g = 0; g < NUM_PHASES; g++) begin : g_lamp
      assign lights[3*g +: 3] = lamp_slice(r_state, r_phase == PH_W'(g));
   end
   assign active_phase     = r_phase;
   assign emergency_active = r_state == EMERG_HOLD;
   assign phase_start      = r_phase_start;

`ifdef TRAFFIC_PED_WALK_EN
   logic [NUM_PHASES-1:0] r_ped, r_walk, w_ped, w_start;
   logic [7:0] r_walk_cnt, r_walk_lim, w_walk_lim;
   logic w_enter_green;
   logic [PH_W-1:0] w_green_ph;
   assign w_ped = r_ped | ped_req;
   assign w_dem = demand | r_ped;
   assign w_enter_green = (r_state == ALL_RED && w_exp) || (r_state == EMERG_HOLD && !w_emerg_any);
   assign w_green_ph = (r_state == ALL_RED) ? w_next : r_phase;
   assign w_start = w_enter_green ? (NUM_PHASES'(1) << w_green_ph) & w_ped : '0;
   assign w_walk_lim = (32'(w_gmin) > 32'd255) ? 8'd255 : 8'(w_gmin);
   assign walk = r_walk & {NUM_PHASES{r_state == GREEN}};
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ped      <= '0;
         r_walk     <= '0;
         r_walk_cnt <= '0;
         r_walk_lim <= '0;
      end else begin
         r_ped <= w_ped & ~w_start;
         if (|w_start) begin
            r_walk     <= w_start;
            r_walk_cnt <= '0;
            r_walk_lim <= w_walk_lim;
         end else if (r_state != GREEN || r_walk_cnt == r_walk_lim) r_walk <= '0;
         else if (tick) r_walk_cnt <= r_walk_cnt + 1'b1;
      end
   end
`else
   assign w_dem = demand;
`endif
endmodule

// File: tb/tb_traffic_phase_controller.sv
// tb_traffic_phase_controller: scoreboard bench; expected lamp/phase records are queued as stimulus is applied.
module tb_traffic_phase_controller;
   localparam int N = 4;
   typedef struct packed {logic [11:0] l; logic [1:0] ph; logic ea; logic ps;} exp_t;
   logic clk = 1'b0, reset_n = 1'b0, tick = 1'b1;
   logic [7:0] green_time = 8'd3, yellow_time = 8'd2, allred_time = 8'd1;
   logic [N-1:0] demand = 4'b1111, emergency = 4'b0000;
   logic [3*N-1:0] lights;
   logic [1:0] active_phase;
   logic emergency_active, phase_start;
   exp_t q[$];
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   traffic_phase_controller #(.NUM_PHASES(N), .TIMER_W(8)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .tick(tick),
      .green_time(green_time),
      .yellow_time(yellow_time),
      .allred_time(allred_time),
      .demand(demand),
      .emergency(emergency),
      .lights(lights),
      .active_phase(active_phase),
      .emergency_active(emergency_active),
      .phase_start(phase_start)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // kind 0 = green, 1 = yellow, 2 = all-red
   function automatic logic [11:0] lamps(input int kind, input int ph);
      logic [11:0] v;
      v = 12'b100100100100;
      if (kind != 2) v[3*ph +: 3] = (kind == 0) ? 3'b001 : 3'b010;
      return v;
   endfunction

   task automatic seg(input int kind, input int ph, input int n, input int ps = 0, input int ea = 0);
      for (int i = 0; i < n; i++)
         q.push_back('{l: lamps(kind, ph), ph: 2'(ph), ea: 1'(ea), ps: (i == 0) ? 1'(ps) : 1'b0});
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() > 0 && n < 300) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (q.size() > 0) begin
         check("drain_timeout", 32'(q.size()), 0);
         q.delete();
      end
   endtask

   always @(negedge clk) begin
      int nr;
      exp_t e;
      nr = 0;
      for (int i = 0; i < N; i++) nr += (lights[3*i +: 3] != 3'b100) ? 1 : 0;
      check("one_non_red", 32'(nr <= 1), 1);
      if (q.size() > 0) begin
         e = q.pop_front();
         check("lights", 32'(lights), 32'(e.l));
         check("active_phase", 32'(active_phase), 32'(e.ph));
         check("emergency_active", 32'(emergency_active), 32'(e.ea));
         check("phase_start", 32'(phase_start), 32'(e.ps));
      end
   end

   initial begin
      seg(0, 0, 1);
      drain();
      reset_n = 1'b1;
      seg(0, 0, 3);
      seg(1, 0, 3);
      seg(2, 0, 2);
      for (int p = 1; p < N; p++) begin
         seg(0, p, 4, 1);
         seg(1, p, 3);
         seg(2, p, 2);
      end
      seg(0, 0, 1, 1);
      drain();
      demand = 4'b0100;
      seg(0, 0, 3);
      seg(1, 0, 3);
      seg(2, 0, 2);
      seg(0, 2, 1, 1);
      drain();
      seg(0, 2, 15);
      drain();
      demand = 4'b0000;
      seg(0, 2, 15);
      drain();
      demand = 4'b0001;
      seg(1, 2, 3);
      seg(2, 2, 2);
      seg(0, 0, 1, 1);
      seg(0, 0, 1);
      drain();
      emergency = 4'b1000;
      seg(1, 0, 3);
      seg(2, 0, 2);
      seg(0, 3, 1, 1);
      seg(0, 3, 20, 0, 1);
      drain();
      emergency = 4'b0000;
      seg(0, 3, 2);
      drain();
      emergency = 4'b0110;
      seg(1, 3, 3);
      seg(2, 3, 2);
      seg(0, 1, 1, 1);
      seg(0, 1, 10, 0, 1);
      drain();
      emergency = 4'b0100;
      seg(1, 1, 3);
      seg(2, 1, 2);
      seg(0, 2, 1, 1);
      seg(0, 2, 5, 0, 1);
      drain();
      emergency = 4'b0000;
      seg(0, 2, 4);
      seg(1, 2, 1);
      drain();
      reset_n = 1'b0;
      #1;
      check("async_reset_lights", 32'(lights), 32'(12'b100100100001));
      check("async_reset_phase", 32'(active_phase), 0);
      check("async_reset_ea", 32'(emergency_active), 0);
      check("async_reset_ps", 32'(phase_start), 0);
      tick = 1'b0;
      demand = 4'b1111;
      @(negedge clk);
      #1;
      reset_n = 1'b1;
      seg(0, 0, 50);
      drain();
      tick = 1'b1;
      seg(0, 0, 3);
      seg(1, 0, 3);
      seg(2, 0, 2);
      seg(0, 1, 1, 1);
      drain();
      green_time = 8'd0;
      yellow_time = 8'd0;
      allred_time = 8'd0;
      seg(0, 1, 3);
      seg(1, 1, 2);
      seg(2, 1, 2);
      seg(0, 2, 1, 1);
      seg(0, 2, 1);
      seg(1, 2, 2);
      seg(2, 2, 2);
      seg(0, 3, 1, 1);
      drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
